// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter bundle: four requester result ports, flush, and the broadcast bus.
interface cdb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [4*TAG_W-1:0]  req_tag;
  logic [3:0]          req_branch;
  logic [3:0]          req_branch_taken;
  logic [3:0]          req_ready;
  logic                flush;
  logic                cdb_valid;
  logic [DATA_W-1:0]   cdb_data;
  logic [TAG_W-1:0]    cdb_tag;
  logic                cdb_branch;
  logic                cdb_branch_taken;

  // Requester/pipeline side: produces results and flush, observes grants and broadcasts.
  modport master (
    output req_valid, req_data, req_tag, req_branch, req_branch_taken, flush,
    input  req_ready, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_tag, req_branch, req_branch_taken, flush,
    output req_ready, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for four functional-unit results onto a single registered CDB.
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned NUM_REQ = 4;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        grant_c;
  logic [1:0]        grant_idx_c;
  logic              xfer_c;
  logic [1:0]        scan_idx;

  logic              cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic              cdb_branch_q, cdb_branch_d;
  logic              cdb_taken_q, cdb_taken_d;

  // Scan requesters starting at rr_ptr; first valid one wins unless flushing.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = rr_ptr_q;
    xfer_c      = 1'b0;
    scan_idx    = '0;
    if (!bus.flush) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        scan_idx = rr_ptr_q + 2'(k);
        if (!xfer_c && bus.req_valid[scan_idx]) begin
          xfer_c            = 1'b1;
          grant_idx_c       = scan_idx;
          grant_c[scan_idx] = 1'b1;
        end
      end
    end
  end

  // Grant is combinational; forced low while reset is held.
  assign bus.req_ready = rst ? 4'b0000 : grant_c;

  // Next-state: pointer advances past the winner; CDB captures the winner's fields.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = 1'b0;
    cdb_data_d   = cdb_data_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_branch_d = 1'b0;
    cdb_taken_d  = 1'b0;
    if (xfer_c) begin
      rr_ptr_d     = grant_idx_c + 2'd1;
      cdb_valid_d  = 1'b1;
      cdb_data_d   = bus.req_data[int'(grant_idx_c)*DATA_W +: DATA_W];
      cdb_tag_d    = bus.req_tag[int'(grant_idx_c)*TAG_W +: TAG_W];
      cdb_branch_d = bus.req_branch[grant_idx_c];
      cdb_taken_d  = bus.req_branch[grant_idx_c] & bus.req_branch_taken[grant_idx_c];
    end
  end

  // State and broadcast registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_tag_q    <= '0;
      cdb_branch_q <= 1'b0;
      cdb_taken_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_branch_q <= cdb_branch_d;
      cdb_taken_q  <= cdb_taken_d;
    end
  end

  assign bus.cdb_valid        = cdb_valid_q;
  assign bus.cdb_data         = cdb_data_q;
  assign bus.cdb_tag          = cdb_tag_q;
  assign bus.cdb_branch       = cdb_branch_q;
  assign bus.cdb_branch_taken = cdb_taken_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the result data width.
REQ-002 The block SHALL have parameter TAG_W, default 6, giving the ROB/rename tag width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port req_valid  input  4  carries per-requester result-valid bits: [0] int, [1] mult, [2] div, [3] ldst.
REQ-006 Port req_data  input  4*DATA_W  carries per-requester result data; requester i uses bits [i*DATA_W +: DATA_W].
REQ-007 Port req_tag  input  4*TAG_W  carries per-requester destination tags; requester i uses bits [i*TAG_W +: TAG_W].
REQ-008 Port req_branch  input  4  marks a per-requester result as a branch resolution.
REQ-009 Port req_branch_taken  input  4  carries the per-requester branch outcome; it is meaningful only when req_branch is 1.
REQ-010 Port req_ready  output  4  is the per-requester grant; at most one bit SHALL be 1 in any cycle.
REQ-011 Port flush  input  1  is the mispredict flush and is synchronous.
REQ-012 Port cdb_valid  output  1  signals a broadcast on the common data bus.
REQ-013 Port cdb_data  output  DATA_W  is the broadcast data.
REQ-014 Port cdb_tag  output  TAG_W  is the broadcast tag.
REQ-015 Ports cdb_branch and cdb_branch_taken  output  1 each  are the broadcast branch flags.

Function
REQ-016 A transfer from requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; requesters hold data stable until they see a transfer.
REQ-017 req_ready SHALL be combinational from req_valid, the round-robin pointer rr_ptr (2 bits) and flush.
REQ-018 The grant SHALL go to the first i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, ... modulo 4.
REQ-019 req_ready SHALL be 4'b0000 when req_valid is 0 or when flush is 1.
REQ-020 After a transfer from requester g, rr_ptr SHALL become (g+1) mod 4 (2-bit wrap, e.g. g=3 gives 0); with no transfer, rr_ptr SHALL hold.
REQ-021 All cdb_* outputs SHALL be registered, with latency of exactly 1 cycle: in the cycle after a transfer from g, cdb_valid=1 and cdb_data/cdb_tag/cdb_branch/cdb_branch_taken equal requester g's fields.
REQ-022 In the cycle after a cycle with no transfer, cdb_valid SHALL be 0; cdb_data/cdb_tag SHALL hold their previous values, and cdb_branch/cdb_branch_taken SHALL be 0.
REQ-023 When flush is 1: no transfer occurs, next cdb_valid=0, rr_ptr holds; a broadcast already on the cdb_* outputs during the flush cycle is still presented in that cycle.
REQ-024 Throughput SHALL be one broadcast per cycle when any request is pending, with no bubbles between back-to-back grants.
REQ-025 A requester with req_valid held at 1 SHALL be granted within 4 cycles of rr_ptr-fair rotation, provided flush stays 0.

Reset
REQ-026 While rst=1: cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_branch=0, cdb_branch_taken=0, rr_ptr=0, req_ready=0.
REQ-027 Assertion of rst mid-transfer SHALL discard the pending result; after deassertion, arbitration SHALL restart from rr_ptr=0.

Verification
REQ-028 After reset, req_valid=4'b0010, mult data=32'h0000_0007, tag=6'd5 -> req_ready=4'b0010 that cycle; next cycle cdb_valid=1, cdb_data=7, cdb_tag=5, and rr_ptr becomes 2.
REQ-029 All four req_valid held at 1 from reset -> grants in order 0,1,2,3,0 on consecutive cycles, with cdb_valid=1 continuously from the second cycle.
REQ-030 rr_ptr=3 with req_valid=4'b1001 -> grant 3 (rr_ptr becomes 0), then grant 0.
REQ-031 flush=1 with req_valid=4'b1111 -> req_ready=0; next cycle cdb_valid=0 and rr_ptr is unchanged.
REQ-032 Branch result from int port (req_branch[0]=1, taken=1, tag=6'd12) -> next cycle cdb_branch=1, cdb_branch_taken=1, cdb_tag=12; the following idle cycle gives cdb_branch=0.
REQ-033 rst asserted asynchronously mid-cycle while cdb_valid=1 -> cdb_valid drops immediately with no clock edge, and all outputs are 0.
